// File: rtl/reloj_bcd_tiempo.sv
// reloj_bcd_tiempo: time-of-day counter for the on-screen clock digit printer.
// Divides clk down to a 1 Hz tick and keeps hh:mm:ss as six registered BCD digits.
// The load port is validated, and the run input pauses both the prescaler and the digits.
// Optional feature: define RELOJ_12H_EN to count hours 12,01..11 with a pm flag.
// Loads always arrive in 24 h format and are converted to 12 h when the feature is enabled.
module reloj_bcd_tiempo #(
    parameter int CLK_HZ = 100_000_000,
    parameter int PRE_W  = 27
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       set_en,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic       set_err,
    output logic       tick_1hz,
    output logic       upd,
    output logic [3:0] segundosU,
    output logic [3:0] segundosD,
    output logic [3:0] minutosU,
    output logic [3:0] minutosD,
    output logic [3:0] horasU,
    output logic [3:0] horasD,
    output logic       pm
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

`ifdef RELOJ_12H_EN
    localparam logic [3:0] HOR_D_RST = 4'd1;
    localparam logic [3:0] HOR_U_RST = 4'd2;
`else
    localparam logic [3:0] HOR_D_RST = 4'd0;
    localparam logic [3:0] HOR_U_RST = 4'd0;
`endif

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       segU_q, segU_d, segD_q, segD_d;
    logic [3:0]       minU_q, minU_d, minD_q, minD_d;
    logic [3:0]       horU_q, horU_d, horD_q, horD_d;
    logic             tick_q, tick_d, upd_q, upd_d, err_q, err_d;
`ifdef RELOJ_12H_EN
    logic             pm_q, pm_d;
`endif

    logic       wrap;
    logic       loadOk;
    logic [3:0] setHD, setHU;

    assign setHD = set_hh[7:4];
    assign setHU = set_hh[3:0];

    // A prescaler wrap only counts while running; a load is accepted only if every field is in range.
    always_comb begin
        wrap   = run && (pre_q == PRE_MAX);
        loadOk = ((setHD < 4'd2 && setHU <= 4'd9) || (setHD == 4'd2 && setHU <= 4'd3)) &&
                 (set_mm[7:4] <= 4'd5 && set_mm[3:0] <= 4'd9) &&
                 (set_ss[7:4] <= 4'd5 && set_ss[3:0] <= 4'd9);
    end

    // Next-state: a load beats a wrap on the same edge, then the BCD cascade runs on a wrap.
    always_comb begin
        pre_d  = pre_q;
        segU_d = segU_q;
        segD_d = segD_q;
        minU_d = minU_q;
        minD_d = minD_q;
        horU_d = horU_q;
        horD_d = horD_q;
        tick_d = 1'b0;
        upd_d  = 1'b0;
        err_d  = 1'b0;
`ifdef RELOJ_12H_EN
        pm_d   = pm_q;
`endif
        if (set_en) begin
            if (loadOk) begin
                pre_d  = '0;
                upd_d  = 1'b1;
                segU_d = set_ss[3:0];
                segD_d = set_ss[7:4];
                minU_d = set_mm[3:0];
                minD_d = set_mm[7:4];
`ifdef RELOJ_12H_EN
                if (setHD == 4'd0 && setHU == 4'd0) begin
                    horD_d = 4'd1;
                    horU_d = 4'd2;
                    pm_d   = 1'b0;
                end else if (setHD == 4'd0 || (setHD == 4'd1 && setHU <= 4'd1)) begin
                    horD_d = setHD;
                    horU_d = setHU;
                    pm_d   = 1'b0;
                end else if (setHD == 4'd1 && setHU == 4'd2) begin
                    horD_d = 4'd1;
                    horU_d = 4'd2;
                    pm_d   = 1'b1;
                end else if (setHD == 4'd1) begin
                    horD_d = 4'd0;
                    horU_d = setHU - 4'd2;
                    pm_d   = 1'b1;
                end else if (setHU <= 4'd1) begin
                    horD_d = 4'd0;
                    horU_d = setHU + 4'd8;
                    pm_d   = 1'b1;
                end else begin
                    horD_d = 4'd1;
                    horU_d = setHU - 4'd2;
                    pm_d   = 1'b1;
                end
`else
                horD_d = setHD;
                horU_d = setHU;
`endif
            end else begin
                err_d = 1'b1;
            end
        end else if (run) begin
            if (wrap) begin
                pre_d  = '0;
                tick_d = 1'b1;
                upd_d  = 1'b1;
                if (segU_q != 4'd9) begin
                    segU_d = segU_q + 4'd1;
                end else begin
                    segU_d = 4'd0;
                    if (segD_q != 4'd5) begin
                        segD_d = segD_q + 4'd1;
                    end else begin
                        segD_d = 4'd0;
                        if (minU_q != 4'd9) begin
                            minU_d = minU_q + 4'd1;
                        end else begin
                            minU_d = 4'd0;
                            if (minD_q != 4'd5) begin
                                minD_d = minD_q + 4'd1;
                            end else begin
                                minD_d = 4'd0;
`ifdef RELOJ_12H_EN
                                if (horD_q == 4'd1 && horU_q == 4'd2) begin
                                    horD_d = 4'd0;
                                    horU_d = 4'd1;
                                end else if (horD_q == 4'd1 && horU_q == 4'd1) begin
                                    horU_d = 4'd2;
                                    pm_d   = ~pm_q;
                                end else if (horU_q == 4'd9) begin
                                    horD_d = 4'd1;
                                    horU_d = 4'd0;
                                end else begin
                                    horU_d = horU_q + 4'd1;
                                end
`else
                                if (horD_q == 4'd2 && horU_q == 4'd3) begin
                                    horD_d = 4'd0;
                                    horU_d = 4'd0;
                                end else if (horU_q == 4'd9) begin
                                    horD_d = horD_q + 4'd1;
                                    horU_d = 4'd0;
                                end else begin
                                    horU_d = horU_q + 4'd1;
                                end
`endif
                            end
                        end
                    end
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // State and output registers; a low reset_n at the edge overrides everything else.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_q  <= '0;
            segU_q <= 4'd0;
            segD_q <= 4'd0;
            minU_q <= 4'd0;
            minD_q <= 4'd0;
            horU_q <= HOR_U_RST;
            horD_q <= HOR_D_RST;
            tick_q <= 1'b0;
            upd_q  <= 1'b0;
            err_q  <= 1'b0;
`ifdef RELOJ_12H_EN
            pm_q   <= 1'b0;
`endif
        end else begin
            pre_q  <= pre_d;
            segU_q <= segU_d;
            segD_q <= segD_d;
            minU_q <= minU_d;
            minD_q <= minD_d;
            horU_q <= horU_d;
            horD_q <= horD_d;
            tick_q <= tick_d;
            upd_q  <= upd_d;
            err_q  <= err_d;
`ifdef RELOJ_12H_EN
            pm_q   <= pm_d;
`endif
        end
    end

    assign segundosU = segU_q;
    assign segundosD = segD_q;
    assign minutosU  = minU_q;
    assign minutosD  = minD_q;
    assign horasU    = horU_q;
    assign horasD    = horD_q;
    assign tick_1hz  = tick_q;
    assign upd       = upd_q;
    assign set_err   = err_q;
`ifdef RELOJ_12H_EN
    assign pm        = pm_q;
`else
    assign pm        = 1'b0;
`endif

endmodule
